// File: rtl/host_cmd_tx_pkg.sv
// Shared definitions for the host command transmitter: opcodes, command
// encodings, serializer FSM states and per-command byte counts.
package host_cmd_tx_pkg;

    localparam logic [7:0] OPC_RF_WR   = 8'hAA;
    localparam logic [7:0] OPC_RF_RD   = 8'hBB;
    localparam logic [7:0] OPC_ALU_OP  = 8'hCC;
    localparam logic [7:0] OPC_ALU_NOP = 8'hDD;

    typedef enum logic [1:0] {
        CMD_RF_WR   = 2'd0,
        CMD_RF_RD   = 2'd1,
        CMD_ALU_OP  = 2'd2,
        CMD_ALU_NOP = 2'd3
    } cmd_type_e;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START,
        ST_DATA,
        ST_PARITY,
        ST_STOP,
        ST_GAP
    } tx_state_e;

    // Bytes on the line per command type, indexed by cmd_type_e.
    localparam logic [2:0] CMD_BYTES [4] = '{3'd3, 3'd2, 3'd4, 3'd2};

    function automatic logic [1:0] last_byte_idx(input cmd_type_e t);
        return 2'(CMD_BYTES[t] - 3'd1);
    endfunction

endpackage

// File: rtl/host_cmd_tx_ser.sv
// uart_frame_ser: one byte -> start/data/[parity]/stop/gap frame, each bit
// PRESCALE clocks. Parity bit present only with HOST_CMD_TX_PAR_EN defined.
module uart_frame_ser
    import host_cmd_tx_pkg::*;
#(
    parameter int DATA_WIDTH = 8,
    parameter int PRESCALE   = 32,
    parameter int GAP_BITS   = 1,
    parameter int PAR_TYPE   = 0
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic                  start_i,
    input  logic [DATA_WIDTH-1:0] byte_i,
    input  logic                  more_i,
    output logic                  tx_o,
    output logic                  idle_o,
    output logic                  frame_end_o
);

    localparam logic [7:0] PRE_LAST  = 8'(PRESCALE - 1);
    localparam logic [7:0] DATA_LAST = 8'(DATA_WIDTH - 1);
    localparam logic [7:0] GAP_LAST  = 8'(GAP_BITS - 1);
    localparam logic       PAR_ODD   = (PAR_TYPE != 0);

    tx_state_e             state_q, state_d;
    logic [7:0]            pre_q, pre_d;
    logic [7:0]            bit_q, bit_d;
    logic [DATA_WIDTH-1:0] shift_q, shift_d;
    logic                  par_q, par_d;
    logic                  tx_q, tx_d;
    logic                  tick;
    logic                  frame_end;

    assign tick = (pre_q == PRE_LAST);

    always_comb begin
        state_d   = state_q;
        pre_d     = tick ? 8'd0 : pre_q + 8'd1;
        bit_d     = bit_q;
        shift_d   = shift_q;
        par_d     = par_q;
        frame_end = 1'b0;
        tx_d      = 1'b1;
        case (state_q)
            ST_IDLE: begin
                pre_d = 8'd0;
                if (start_i) state_d = ST_START;
            end
            // Byte is sampled at the end of the start bit, so the sequencer
            // can advance its index on the same edge a frame finishes.
            ST_START: if (tick) begin
                shift_d = byte_i;
                par_d   = (^byte_i) ^ PAR_ODD;
                bit_d   = 8'd0;
                state_d = ST_DATA;
            end
            ST_DATA: if (tick) begin
                if (bit_q == DATA_LAST) begin
                    bit_d = 8'd0;
`ifdef HOST_CMD_TX_PAR_EN
                    state_d = ST_PARITY;
`else
                    state_d = ST_STOP;
`endif
                end else begin
                    bit_d   = bit_q + 8'd1;
                    shift_d = shift_q >> 1;
                end
            end
            ST_PARITY: if (tick) state_d = ST_STOP;
            ST_STOP: if (tick) begin
                if (GAP_BITS == 0) begin
                    frame_end = 1'b1;
                    state_d   = more_i ? ST_START : ST_IDLE;
                end else begin
                    state_d = ST_GAP;
                end
            end
            ST_GAP: if (tick) begin
                if (bit_q == GAP_LAST) begin
                    frame_end = 1'b1;
                    bit_d     = 8'd0;
                    state_d   = more_i ? ST_START : ST_IDLE;
                end else begin
                    bit_d = bit_q + 8'd1;
                end
            end
            default: state_d = ST_IDLE;
        endcase
        case (state_d)
            ST_START:  tx_d = 1'b0;
            ST_DATA:   tx_d = shift_d[0];
            ST_PARITY: tx_d = par_d;
            default:   tx_d = 1'b1;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= ST_IDLE;
            pre_q   <= 8'd0;
            bit_q   <= 8'd0;
            shift_q <= '0;
            par_q   <= 1'b0;
            tx_q    <= 1'b1;
        end else begin
            state_q <= state_d;
            pre_q   <= pre_d;
            bit_q   <= bit_d;
            shift_q <= shift_d;
            par_q   <= par_d;
            tx_q    <= tx_d;
        end
    end

    assign tx_o        = tx_q;
    assign idle_o      = (state_q == ST_IDLE);
    assign frame_end_o = frame_end;

endmodule

// File: rtl/host_cmd_tx.sv
// Host command transmitter: captures a command, expands it into opcode and
// operand bytes and streams them as UART frames. Build macro: HOST_CMD_TX_PAR_EN.
module host_cmd_tx
    import host_cmd_tx_pkg::*;
#(
    parameter int DATA_WIDTH = 8,
    parameter int PRESCALE   = 32,
    parameter int GAP_BITS   = 1,
    parameter int PAR_TYPE   = 0
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic                  cmd_valid,
    output logic                  cmd_ready,
    input  logic [1:0]            cmd_type,
    input  logic [DATA_WIDTH-1:0] cmd_addr,
    input  logic [DATA_WIDTH-1:0] cmd_data_a,
    input  logic [DATA_WIDTH-1:0] cmd_data_b,
    input  logic [3:0]            cmd_fun,
    output logic                  tx_out,
    output logic                  busy,
    output logic                  cmd_done
);

    logic                  ready_en_q;
    logic [1:0]            idx_q;
    logic [1:0]            last_q;
    logic [DATA_WIDTH-1:0] byte_q    [4];
    logic [DATA_WIDTH-1:0] load_byte [4];
    logic [DATA_WIDTH-1:0] fun_ext;
    logic                  accept;
    logic                  more;
    logic                  ser_idle;
    logic                  frame_end;

    assign fun_ext   = DATA_WIDTH'(cmd_fun);
    assign cmd_ready = ready_en_q & ser_idle;
    assign accept    = cmd_valid & cmd_ready;
    assign more      = (idx_q != last_q);
    assign busy      = ~ser_idle;
    assign cmd_done  = frame_end & ~more;

    always_comb begin
        for (int i = 0; i < 4; i++) load_byte[i] = '0;
        case (cmd_type_e'(cmd_type))
            CMD_RF_WR: begin
                load_byte[0] = DATA_WIDTH'(OPC_RF_WR);
                load_byte[1] = cmd_addr;
                load_byte[2] = cmd_data_a;
            end
            CMD_RF_RD: begin
                load_byte[0] = DATA_WIDTH'(OPC_RF_RD);
                load_byte[1] = cmd_addr;
            end
            CMD_ALU_OP: begin
                load_byte[0] = DATA_WIDTH'(OPC_ALU_OP);
                load_byte[1] = cmd_data_a;
                load_byte[2] = cmd_data_b;
                load_byte[3] = fun_ext;
            end
            CMD_ALU_NOP: begin
                load_byte[0] = DATA_WIDTH'(OPC_ALU_NOP);
                load_byte[1] = fun_ext;
            end
        endcase
    end

    // ready_en_q keeps cmd_ready low until the first edge out of reset.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            ready_en_q <= 1'b0;
            idx_q      <= 2'd0;
            last_q     <= 2'd0;
            for (int i = 0; i < 4; i++) byte_q[i] <= '0;
        end else begin
            ready_en_q <= 1'b1;
            if (accept) begin
                idx_q  <= 2'd0;
                last_q <= last_byte_idx(cmd_type_e'(cmd_type));
                for (int i = 0; i < 4; i++) byte_q[i] <= load_byte[i];
            end else if (frame_end && more) begin
                idx_q <= idx_q + 2'd1;
            end
        end
    end

    uart_frame_ser #(
        .DATA_WIDTH (DATA_WIDTH),
        .PRESCALE   (PRESCALE),
        .GAP_BITS   (GAP_BITS),
        .PAR_TYPE   (PAR_TYPE)
    ) u_ser (
        .clk_i       (CLK),
        .rst_ni      (RST),
        .start_i     (accept),
        .byte_i      (byte_q[idx_q]),
        .more_i      (more),
        .tx_o        (tx_out),
        .idle_o      (ser_idle),
        .frame_end_o (frame_end)
    );

endmodule

// File: tb/tb_host_cmd_tx.sv
// Bench for host_cmd_tx: per-cycle reference model of the serial line plus
// directed commands with literal latency, byte and parity expectations.
`timescale 1ns/1ps
module tb_host_cmd_tx;

    localparam int DW  = 8;
    localparam int P   = 4;
    localparam int GAP = 1;
    localparam int PT  = 0;
`ifdef HOST_CMD_TX_PAR_EN
    localparam int NBITS = 11;
    localparam int L_WR  = 144;
    localparam int B_ALU = 192;
    localparam int L_RD  = 96;
`else
    localparam int NBITS = 10;
    localparam int L_WR  = 132;
    localparam int B_ALU = 176;
    localparam int L_RD  = 88;
`endif
    localparam int FR = (NBITS + GAP) * P;

    logic          CLK = 1'b0;
    logic          RST = 1'b0;
    logic          cmd_valid = 1'b0;
    logic          cmd_ready;
    logic [1:0]    cmd_type = 2'd0;
    logic [DW-1:0] cmd_addr = '0;
    logic [DW-1:0] cmd_data_a = '0;
    logic [DW-1:0] cmd_data_b = '0;
    logic [3:0]    cmd_fun = 4'd0;
    logic          tx_out;
    logic          busy;
    logic          cmd_done;

    always #5 CLK = ~CLK;

    host_cmd_tx #(.DATA_WIDTH(DW), .PRESCALE(P), .GAP_BITS(GAP), .PAR_TYPE(PT)) dut (
        .CLK(CLK), .RST(RST), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_type(cmd_type), .cmd_addr(cmd_addr), .cmd_data_a(cmd_data_a),
        .cmd_data_b(cmd_data_b), .cmd_fun(cmd_fun), .tx_out(tx_out),
        .busy(busy), .cmd_done(cmd_done)
    );

    int checks = 0;
    int failures = 0;
    int cyc = 0;
    logic rec [0:1023];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference model: one entry per clock cycle of the expected line state.
    typedef struct packed { logic tx; logic busy; logic done; } exp_t;
    exp_t exp_q[$];
    logic armed = 1'b0;

    function automatic void push_cmd(input logic [1:0] t, input logic [7:0] addr,
                                     input logic [7:0] a, input logic [7:0] b, input logic [3:0] fun);
        logic [7:0] bl[$];
        case (t)
            2'd0: begin bl.push_back(8'hAA); bl.push_back(addr); bl.push_back(a); end
            2'd1: begin bl.push_back(8'hBB); bl.push_back(addr); end
            2'd2: begin bl.push_back(8'hCC); bl.push_back(a); bl.push_back(b); bl.push_back({4'h0, fun}); end
            default: begin bl.push_back(8'hDD); bl.push_back({4'h0, fun}); end
        endcase
        for (int j = 0; j < bl.size(); j++) begin
            logic bits[$];
            bits.push_back(1'b0);
            for (int k = 0; k < 8; k++) bits.push_back(bl[j][k]);
`ifdef HOST_CMD_TX_PAR_EN
            bits.push_back((^bl[j]) ^ (PT != 0));
`endif
            bits.push_back(1'b1);
            for (int g = 0; g < GAP; g++) bits.push_back(1'b1);
            for (int i = 0; i < bits.size(); i++)
                for (int c = 0; c < P; c++) begin
                    exp_t e;
                    e.tx   = bits[i];
                    e.busy = 1'b1;
                    e.done = (j == bl.size() - 1) && (i == bits.size() - 1) && (c == P - 1);
                    exp_q.push_back(e);
                end
        end
    endfunction

    always @(posedge CLK or negedge RST) begin
        if (!RST) begin
            exp_q.delete();
            armed <= 1'b0;
        end else begin
            if (exp_q.size() != 0) void'(exp_q.pop_front());
            else if (cmd_valid && armed) push_cmd(cmd_type, cmd_addr, cmd_data_a, cmd_data_b, cmd_fun);
            armed <= 1'b1;
        end
    end

    always @(posedge CLK) cyc <= cyc + 1;

    always @(negedge CLK) begin
        if (!RST) begin
            chk("rst_tx", tx_out, 1); chk("rst_busy", busy, 0);
            chk("rst_done", cmd_done, 0); chk("rst_ready", cmd_ready, 0);
        end else if (exp_q.size() != 0) begin
            chk("tx", tx_out, exp_q[0].tx); chk("busy", busy, exp_q[0].busy);
            chk("done", cmd_done, exp_q[0].done); chk("ready", cmd_ready, 0);
        end else begin
            chk("idle_tx", tx_out, 1); chk("idle_busy", busy, 0);
            chk("idle_done", cmd_done, 0); chk("idle_ready", cmd_ready, armed);
        end
    end

    function automatic logic [7:0] dec_byte(input int j);
        logic [7:0] v;
        for (int k = 0; k < 8; k++) v[k] = rec[j*FR + (1+k)*P + P/2];
        return v;
    endfunction

    function automatic logic dec_par(input int j);
        return rec[j*FR + 9*P + P/2];
    endfunction

    task automatic run_cmd(input logic [1:0] t, input logic [7:0] addr, input logic [7:0] a,
                           input logic [7:0] b, input logic [3:0] fun, input bit hold,
                           output int lat, output int busy_n, output int first_rel,
                           output int first_abs, output int done_abs);
        bit got;
        for (int n = 0; n < 400 && cmd_ready !== 1'b1; n++) @(negedge CLK);
        chk("ready_before_issue", cmd_ready, 1);
        cmd_type = t; cmd_addr = addr; cmd_data_a = a; cmd_data_b = b; cmd_fun = fun;
        cmd_valid = 1'b1;
        @(posedge CLK);
        @(negedge CLK);
        if (!hold) cmd_valid = 1'b0;
        got = 0; lat = 0; busy_n = 0; first_rel = 0; first_abs = 0; done_abs = 0;
        for (int i = 1; i <= 600 && !got; i++) begin
            if (i > 1) @(negedge CLK);
            rec[i-1] = tx_out;
            if (busy) busy_n++;
            if (!tx_out && first_rel == 0) begin first_rel = i; first_abs = cyc; end
            if (hold) begin
                cmd_type = 2'($urandom); cmd_addr = 8'($urandom);
                cmd_data_a = 8'($urandom); cmd_data_b = 8'($urandom); cmd_fun = 4'($urandom);
            end
            if (cmd_done) begin
                got = 1; lat = i; done_abs = cyc;
                cmd_valid = 1'b0;
            end
        end
        chk("done_seen", got, 1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int lat, bn, fr, fa, da, da_prev;
        repeat (3) @(negedge CLK);
        chk("reset_tx", tx_out, 1);
        chk("reset_ready", cmd_ready, 0);
        @(posedge CLK); #2 RST = 1'b1;
        @(negedge CLK);
        chk("ready_low_before_edge", cmd_ready, 0);
        @(negedge CLK);
        chk("ready_after_release", cmd_ready, 1);

        run_cmd(2'd0, 8'h05, 8'h3C, 8'h00, 4'h0, 0, lat, bn, fr, fa, da);
        $display("cmd wr addr=05 data=3C lat=%0d", lat);
        chk("wr_latency", lat, L_WR);
        chk("wr_start_latency", fr, 1);
        chk("wr_b0", dec_byte(0), 8'hAA); chk("wr_b1", dec_byte(1), 8'h05); chk("wr_b2", dec_byte(2), 8'h3C);
`ifdef HOST_CMD_TX_PAR_EN
        chk("wr_p0", dec_par(0), 0); chk("wr_p1", dec_par(1), 0); chk("wr_p2", dec_par(2), 0);
`endif

        run_cmd(2'd2, 8'h00, 8'h07, 8'h03, 4'h1, 0, lat, bn, fr, fa, da);
        $display("cmd alu a=07 b=03 fun=1 busy=%0d", bn);
        chk("alu_busy_cycles", bn, B_ALU);
        chk("alu_b0", dec_byte(0), 8'hCC); chk("alu_b1", dec_byte(1), 8'h07);
        chk("alu_b2", dec_byte(2), 8'h03); chk("alu_b3", dec_byte(3), 8'h01);
`ifdef HOST_CMD_TX_PAR_EN
        chk("alu_p0", dec_par(0), 0); chk("alu_p1", dec_par(1), 1);
        chk("alu_p2", dec_par(2), 0); chk("alu_p3", dec_par(3), 1);
`endif

        run_cmd(2'd1, 8'h02, 8'h00, 8'h00, 4'h0, 0, lat, bn, fr, fa, da);
        $display("cmd rd addr=02 lat=%0d", lat);
        chk("rd_latency", lat, L_RD);
        chk("rd_b0", dec_byte(0), 8'hBB); chk("rd_b1", dec_byte(1), 8'h02);
        da_prev = da;
        run_cmd(2'd3, 8'h00, 8'h00, 8'h00, 4'h4, 0, lat, bn, fr, fa, da);
        $display("cmd alu_nop fun=4 idle_gap=%0d", fa - (da_prev - GAP*P) - 1);
        chk("b2b_idle_gap", fa - (da_prev - GAP*P) - 1, 5);
        chk("nop_b0", dec_byte(0), 8'hDD); chk("nop_b1", dec_byte(1), 8'h04);

        run_cmd(2'd0, 8'h11, 8'h22, 8'h00, 4'h0, 1, lat, bn, fr, fa, da);
        $display("cmd wr held-valid addr=11 data=22 lat=%0d", lat);
        chk("hold_latency", lat, L_WR);
        chk("hold_b0", dec_byte(0), 8'hAA); chk("hold_b1", dec_byte(1), 8'h11); chk("hold_b2", dec_byte(2), 8'h22);
        repeat (12) @(negedge CLK);
        chk("no_extra_accept", busy, 0);

        for (int n = 0; n < 400 && cmd_ready !== 1'b1; n++) @(negedge CLK);
        cmd_type = 2'd0; cmd_addr = 8'h05; cmd_data_a = 8'h3C; cmd_valid = 1'b1;
        @(posedge CLK);
        @(negedge CLK); cmd_valid = 1'b0;
        repeat (FR + 17) @(negedge CLK);
        @(posedge CLK); #1;
        chk("mid_bit3_low", tx_out, 0);
        RST = 1'b0; #1;
        $display("reset asserted mid data bit3 of byte 1");
        chk("rst_now_tx", tx_out, 1); chk("rst_now_busy", busy, 0);
        chk("rst_now_done", cmd_done, 0); chk("rst_now_ready", cmd_ready, 0);
        repeat (2) @(posedge CLK);
        #2 RST = 1'b1;
        @(negedge CLK);
        chk("rel_ready_before_edge", cmd_ready, 0);
        @(negedge CLK);
        chk("rel_ready_after_edge", cmd_ready, 1);

        run_cmd(2'd1, 8'h0F, 8'h00, 8'h00, 4'h0, 0, lat, bn, fr, fa, da);
        $display("cmd rd addr=0F lat=%0d", lat);
        chk("rd2_latency", lat, L_RD);
        chk("rd2_b0", dec_byte(0), 8'hBB); chk("rd2_b1", dec_byte(1), 8'h0F);

        repeat (10) @(negedge CLK);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
